// File: rtl/mem_stage_pkg.sv
// Shared definitions for the MEM stage: FSM state encoding, word size, default timeout.
package mem_stage_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } state_e;

  localparam int WORD_BYTES             = 4;
  localparam int DEFAULT_TIMEOUT_CYCLES = 16;

  function automatic logic is_memop(input logic valid, input logic rd, input logic wr);
    return valid & (rd | wr);
  endfunction

endpackage

// File: rtl/mem_wb_reg.sv
// MEM/WB pipeline register: loads on enable, inserts a bubble while stalled,
// and records a non-writing valid slot on abort (abort has priority).
module mem_wb_reg (
  input  logic        clock,
  input  logic        reset,
  input  logic        en_i,
  input  logic        bubble_i,
  input  logic        abort_i,
  input  logic        valid_i,
  input  logic        mem_to_reg_i,
  input  logic        reg_write_i,
  input  logic        mem_read_i,
  input  logic [31:0] alu_i,
  input  logic [31:0] rdata_i,
  input  logic [4:0]  rd_i,
  output logic        valid_o,
  output logic        mem_to_reg_o,
  output logic        reg_write_o,
  output logic [31:0] read_data_o,
  output logic [31:0] alu_o,
  output logic [4:0]  rd_o
);

  logic        valid_q, valid_d;
  logic        mem_to_reg_q, mem_to_reg_d;
  logic        reg_write_q, reg_write_d;
  logic [31:0] read_data_q, read_data_d;
  logic [31:0] alu_q, alu_d;
  logic [4:0]  rd_q, rd_d;

  always_comb begin
    valid_d      = valid_q;
    mem_to_reg_d = mem_to_reg_q;
    reg_write_d  = reg_write_q;
    read_data_d  = read_data_q;
    alu_d        = alu_q;
    rd_d         = rd_q;
    if (abort_i) begin
      valid_d      = 1'b1;
      mem_to_reg_d = mem_to_reg_i;
      reg_write_d  = 1'b0;
      read_data_d  = 32'h0;
      alu_d        = alu_i;
      rd_d         = rd_i;
    end else if (en_i) begin
      valid_d      = valid_i;
      mem_to_reg_d = mem_to_reg_i;
      reg_write_d  = reg_write_i;
      read_data_d  = mem_read_i ? rdata_i : 32'h0;
      alu_d        = alu_i;
      rd_d         = rd_i;
    end else if (bubble_i) begin
      valid_d     = 1'b0;
      reg_write_d = 1'b0;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      valid_q      <= 1'b0;
      mem_to_reg_q <= 1'b0;
      reg_write_q  <= 1'b0;
      read_data_q  <= 32'h0;
      alu_q        <= 32'h0;
      rd_q         <= 5'd0;
    end else begin
      valid_q      <= valid_d;
      mem_to_reg_q <= mem_to_reg_d;
      reg_write_q  <= reg_write_d;
      read_data_q  <= read_data_d;
      alu_q        <= alu_d;
      rd_q         <= rd_d;
    end
  end

  assign valid_o      = valid_q;
  assign mem_to_reg_o = mem_to_reg_q;
  assign reg_write_o  = reg_write_q;
  assign read_data_o  = read_data_q;
  assign alu_o        = alu_q;
  assign rd_o         = rd_q;

endmodule

// File: rtl/mem_stage.sv
// RISC-V MEM stage: data-memory req/ack FSM with timeout abort, beq redirect, MEM/WB register.
// Optional MEM_MISALIGN_TRAP_EN: misaligned accesses issue no request and raise bus_err_out.
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int ADDR_W         = 10,
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              valid_in,
  input  logic              mem_to_reg_in,
  input  logic              reg_write_in,
  input  logic              mem_read_in,
  input  logic              mem_write_in,
  input  logic              beq_instruction_in,
  input  logic              flag_beq_in,
  input  logic [31:0]       alu_result_in,
  input  logic [31:0]       mux2_result_in,
  input  logic [4:0]        reg_rd_in,
  output logic              stall_out,
  output logic              pc_src_out,
  output logic              dmem_req_out,
  output logic              dmem_we_out,
  output logic [ADDR_W-1:0] dmem_addr_out,
  output logic [31:0]       dmem_wdata_out,
  input  logic [31:0]       dmem_rdata_in,
  input  logic              dmem_ack_in,
  output logic [4:0]        ex_mem_reg_rd,
  output logic              ex_mem_reg_write,
  output logic [31:0]       alu_ex_mem,
  output logic [4:0]        mem_wb_reg_rd,
  output logic              mem_wb_reg_write,
  output logic [31:0]       alu_data_mem_wb,
  output logic              valid_out,
  output logic              mem_to_reg_out,
  output logic              reg_write_out,
  output logic [31:0]       read_data_out,
  output logic [31:0]       alu_result_out,
  output logic [4:0]        reg_rd_out,
  output logic              bus_err_out
);

  localparam int OFF_W = $clog2(WORD_BYTES);
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT_CYCLES - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic             bus_err_q, bus_err_d;
  logic             memop, misalign, req_raw, timeout_abort, abort;

  assign memop = is_memop(valid_in, mem_read_in, mem_write_in);

`ifdef MEM_MISALIGN_TRAP_EN
  assign misalign = memop & (alu_result_in[OFF_W-1:0] != '0);
`else
  assign misalign = 1'b0;
`endif

  assign req_raw = ((state_q == ST_IDLE) & memop & ~misalign) | (state_q == ST_WAIT);
  assign cnt_inc = cnt_q + CNT_W'(1);

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    timeout_abort = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (req_raw && !dmem_ack_in) begin
          state_d = ST_WAIT;
          cnt_d   = CNT_W'(1);
        end
      end
      ST_WAIT: begin
        if (dmem_ack_in) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else if (cnt_inc >= CNT_LIMIT) begin
          state_d       = ST_IDLE;
          cnt_d         = '0;
          timeout_abort = 1'b1;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  assign abort     = timeout_abort | ((state_q == ST_IDLE) & misalign);
  assign bus_err_d = abort;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      bus_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bus_err_q <= bus_err_d;
    end
  end

  // Combinational outputs are forced low while reset is asserted so a WAIT request drops at once.
  assign dmem_req_out     = reset & req_raw;
  assign stall_out        = dmem_req_out & ~dmem_ack_in;
  assign dmem_we_out      = dmem_req_out & mem_write_in;
  assign dmem_addr_out    = reset ? alu_result_in[ADDR_W+OFF_W-1:OFF_W] : '0;
  assign dmem_wdata_out   = reset ? mux2_result_in : 32'h0;
  assign pc_src_out       = reset & valid_in & beq_instruction_in & flag_beq_in;
  assign ex_mem_reg_write = reset & valid_in & reg_write_in;
  assign ex_mem_reg_rd    = reset ? reg_rd_in : 5'd0;
  assign alu_ex_mem       = reset ? alu_result_in : 32'h0;
  assign bus_err_out      = bus_err_q;

  mem_wb_reg u_mem_wb_reg (
    .clock        (clock),
    .reset        (reset),
    .en_i         (~stall_out),
    .bubble_i     (stall_out),
    .abort_i      (abort),
    .valid_i      (valid_in),
    .mem_to_reg_i (mem_to_reg_in),
    .reg_write_i  (reg_write_in),
    .mem_read_i   (mem_read_in),
    .alu_i        (alu_result_in),
    .rdata_i      (dmem_rdata_in),
    .rd_i         (reg_rd_in),
    .valid_o      (valid_out),
    .mem_to_reg_o (mem_to_reg_out),
    .reg_write_o  (reg_write_out),
    .read_data_o  (read_data_out),
    .alu_o        (alu_result_out),
    .rd_o         (reg_rd_out)
  );

  assign mem_wb_reg_rd    = reg_rd_out;
  assign mem_wb_reg_write = reg_write_out;
  assign alu_data_mem_wb  = mem_to_reg_out ? read_data_out : alu_result_out;

endmodule

// File: tb/tb_mem_stage.sv
// Directed self-checking bench for mem_stage (ADDR_W=10, TIMEOUT_CYCLES=16).
module tb_mem_stage;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        valid_in, mem_to_reg_in, reg_write_in, mem_read_in, mem_write_in;
  logic        beq_instruction_in, flag_beq_in;
  logic [31:0] alu_result_in, mux2_result_in, dmem_rdata_in;
  logic [4:0]  reg_rd_in;
  logic        dmem_ack_in;
  logic        stall_out, pc_src_out, dmem_req_out, dmem_we_out;
  logic [9:0]  dmem_addr_out;
  logic [31:0] dmem_wdata_out;
  logic [4:0]  ex_mem_reg_rd, mem_wb_reg_rd, reg_rd_out;
  logic        ex_mem_reg_write, mem_wb_reg_write;
  logic [31:0] alu_ex_mem, alu_data_mem_wb, read_data_out, alu_result_out;
  logic        valid_out, mem_to_reg_out, reg_write_out, bus_err_out;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  mem_stage #(.ADDR_W(10), .TIMEOUT_CYCLES(16)) dut (
    .clock(clock), .reset(reset),
    .valid_in(valid_in), .mem_to_reg_in(mem_to_reg_in), .reg_write_in(reg_write_in),
    .mem_read_in(mem_read_in), .mem_write_in(mem_write_in),
    .beq_instruction_in(beq_instruction_in), .flag_beq_in(flag_beq_in),
    .alu_result_in(alu_result_in), .mux2_result_in(mux2_result_in), .reg_rd_in(reg_rd_in),
    .stall_out(stall_out), .pc_src_out(pc_src_out), .dmem_req_out(dmem_req_out),
    .dmem_we_out(dmem_we_out), .dmem_addr_out(dmem_addr_out), .dmem_wdata_out(dmem_wdata_out),
    .dmem_rdata_in(dmem_rdata_in), .dmem_ack_in(dmem_ack_in),
    .ex_mem_reg_rd(ex_mem_reg_rd), .ex_mem_reg_write(ex_mem_reg_write), .alu_ex_mem(alu_ex_mem),
    .mem_wb_reg_rd(mem_wb_reg_rd), .mem_wb_reg_write(mem_wb_reg_write),
    .alu_data_mem_wb(alu_data_mem_wb), .valid_out(valid_out), .mem_to_reg_out(mem_to_reg_out),
    .reg_write_out(reg_write_out), .read_data_out(read_data_out), .alu_result_out(alu_result_out),
    .reg_rd_out(reg_rd_out), .bus_err_out(bus_err_out)
  );

  task automatic clear_inputs();
    valid_in = 0; mem_to_reg_in = 0; reg_write_in = 0; mem_read_in = 0; mem_write_in = 0;
    beq_instruction_in = 0; flag_beq_in = 0; alu_result_in = 0; mux2_result_in = 0;
    reg_rd_in = 0; dmem_rdata_in = 0; dmem_ack_in = 0;
  endtask

  task automatic test_reset();
    clear_inputs();
    valid_in = 1; mem_read_in = 1; reg_write_in = 1; beq_instruction_in = 1; flag_beq_in = 1;
    #1;
    checks++; if (dmem_req_out !== 1'b0) begin errors++; $display("FAIL reset_req: got %b want 0", dmem_req_out); end
    checks++; if (stall_out !== 1'b0) begin errors++; $display("FAIL reset_stall: got %b want 0", stall_out); end
    checks++; if (pc_src_out !== 1'b0) begin errors++; $display("FAIL reset_pc_src: got %b want 0", pc_src_out); end
    checks++; if (valid_out !== 1'b0) begin errors++; $display("FAIL reset_valid_out: got %b want 0", valid_out); end
    checks++; if (bus_err_out !== 1'b0) begin errors++; $display("FAIL reset_bus_err: got %b want 0", bus_err_out); end
    clear_inputs();
    @(negedge clock);
    reset = 1;
  endtask

  task automatic test_alu_op();
    @(negedge clock);
    clear_inputs();
    valid_in = 1; reg_write_in = 1; alu_result_in = 32'h8; reg_rd_in = 5'd3;
    #1;
    checks++; if (dmem_req_out !== 1'b0) begin errors++; $display("FAIL alu_req: got %b want 0", dmem_req_out); end
    checks++; if (ex_mem_reg_write !== 1'b1) begin errors++; $display("FAIL alu_fwd_we: got %b want 1", ex_mem_reg_write); end
    checks++; if (ex_mem_reg_rd !== 5'd3) begin errors++; $display("FAIL alu_fwd_rd: got %0d want 3", ex_mem_reg_rd); end
    checks++; if (alu_ex_mem !== 32'h8) begin errors++; $display("FAIL alu_fwd_val: got %h want 8", alu_ex_mem); end
    @(posedge clock); #1;
    checks++; if (valid_out !== 1'b1) begin errors++; $display("FAIL alu_valid_out: got %b want 1", valid_out); end
    checks++; if (alu_data_mem_wb !== 32'h8) begin errors++; $display("FAIL alu_wb_val: got %h want 8", alu_data_mem_wb); end
    checks++; if (mem_wb_reg_rd !== 5'd3) begin errors++; $display("FAIL alu_wb_rd: got %0d want 3", mem_wb_reg_rd); end
    checks++; if (mem_wb_reg_write !== 1'b1) begin errors++; $display("FAIL alu_wb_we: got %b want 1", mem_wb_reg_write); end
  endtask

  task automatic test_back_to_back();
    @(negedge clock);
    clear_inputs();
    valid_in = 1; reg_write_in = 1; alu_result_in = 32'h11; reg_rd_in = 5'd1;
    @(negedge clock);
    checks++; if (alu_data_mem_wb !== 32'h11) begin errors++; $display("FAIL b2b_first: got %h want 11", alu_data_mem_wb); end
    alu_result_in = 32'h22; reg_rd_in = 5'd2; reg_write_in = 0;
    @(posedge clock); #1;
    checks++; if (alu_data_mem_wb !== 32'h22) begin errors++; $display("FAIL b2b_second: got %h want 22", alu_data_mem_wb); end
    checks++; if (reg_write_out !== 1'b0) begin errors++; $display("FAIL b2b_we: got %b want 0", reg_write_out); end
    checks++; if (reg_rd_out !== 5'd2) begin errors++; $display("FAIL b2b_rd: got %0d want 2", reg_rd_out); end
  endtask

  task automatic test_zero_wait_load();
    @(negedge clock);
    clear_inputs();
    valid_in = 1; mem_read_in = 1; mem_to_reg_in = 1; reg_write_in = 1;
    alu_result_in = 32'h10; reg_rd_in = 5'd5; dmem_ack_in = 1; dmem_rdata_in = 32'hCAFE;
    #1;
    checks++; if (dmem_req_out !== 1'b1) begin errors++; $display("FAIL zw_req: got %b want 1", dmem_req_out); end
    checks++; if (stall_out !== 1'b0) begin errors++; $display("FAIL zw_stall: got %b want 0", stall_out); end
    checks++; if (dmem_addr_out !== 10'd4) begin errors++; $display("FAIL zw_addr: got %0d want 4", dmem_addr_out); end
    checks++; if (dmem_we_out !== 1'b0) begin errors++; $display("FAIL zw_we: got %b want 0", dmem_we_out); end
    @(posedge clock); #1;
    checks++; if (read_data_out !== 32'hCAFE) begin errors++; $display("FAIL zw_rdata: got %h want cafe", read_data_out); end
    checks++; if (alu_data_mem_wb !== 32'hCAFE) begin errors++; $display("FAIL zw_wb_val: got %h want cafe", alu_data_mem_wb); end
    checks++; if (valid_out !== 1'b1) begin errors++; $display("FAIL zw_valid: got %b want 1", valid_out); end
  endtask

  task automatic test_store_wait();
    @(negedge clock);
    clear_inputs();
    valid_in = 1; mem_write_in = 1; alu_result_in = 32'h10; mux2_result_in = 32'h55;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++; if (stall_out !== 1'b1) begin errors++; $display("FAIL st_stall[%0d]: got %b want 1", i, stall_out); end
      checks++; if (dmem_we_out !== 1'b1 || dmem_addr_out !== 10'd4 || dmem_wdata_out !== 32'h55) begin
        errors++; $display("FAIL st_bus[%0d]: got we=%b addr=%0d wdata=%h want we=1 addr=4 wdata=55", i, dmem_we_out, dmem_addr_out, dmem_wdata_out);
      end
      @(posedge clock); #1;
      checks++; if (valid_out !== 1'b0) begin errors++; $display("FAIL st_bubble[%0d]: got %b want 0", i, valid_out); end
      @(negedge clock);
    end
    dmem_ack_in = 1;
    #1;
    checks++; if (stall_out !== 1'b0) begin errors++; $display("FAIL st_ack_stall: got %b want 0", stall_out); end
    @(posedge clock); #1;
    checks++; if (valid_out !== 1'b1) begin errors++; $display("FAIL st_done_valid: got %b want 1", valid_out); end
    checks++; if (reg_write_out !== 1'b0) begin errors++; $display("FAIL st_done_we: got %b want 0", reg_write_out); end
  endtask

  task automatic test_beq();
    @(negedge clock);
    clear_inputs();
    valid_in = 1; beq_instruction_in = 1; flag_beq_in = 1;
    #1;
    checks++; if (pc_src_out !== 1'b1) begin errors++; $display("FAIL beq_taken: got %b want 1", pc_src_out); end
    flag_beq_in = 0;
    #1;
    checks++; if (pc_src_out !== 1'b0) begin errors++; $display("FAIL beq_flag0: got %b want 0", pc_src_out); end
    flag_beq_in = 1; valid_in = 0;
    #1;
    checks++; if (pc_src_out !== 1'b0) begin errors++; $display("FAIL beq_invalid: got %b want 0", pc_src_out); end
  endtask

  task automatic test_timeout();
    int stalls = 0;
    bit seen_err = 0;
    @(negedge clock);
    clear_inputs();
    valid_in = 1; mem_read_in = 1; mem_to_reg_in = 1; reg_write_in = 1;
    alu_result_in = 32'h20; reg_rd_in = 5'd7;
    for (int i = 0; i < 40; i++) begin
      #1;
      if (stall_out !== 1'b1) break;
      stalls++;
      @(posedge clock); #1;
      if (bus_err_out === 1'b1) begin
        seen_err = 1;
        checks++; if (valid_out !== 1'b1) begin errors++; $display("FAIL to_valid: got %b want 1", valid_out); end
        checks++; if (reg_write_out !== 1'b0) begin errors++; $display("FAIL to_we: got %b want 0", reg_write_out); end
        valid_in = 0; mem_read_in = 0;
        #1;
        checks++; if (stall_out !== 1'b0) begin errors++; $display("FAIL to_stall_drop: got %b want 0", stall_out); end
        break;
      end
      @(negedge clock);
    end
    checks++; if (stalls != 15) begin errors++; $display("FAIL to_stall_cycles: got %0d want 15", stalls); end
    checks++; if (seen_err != 1'b1) begin errors++; $display("FAIL to_bus_err_seen: got %0d want 1", seen_err); end
    @(posedge clock); #1;
    checks++; if (bus_err_out !== 1'b0) begin errors++; $display("FAIL to_pulse_width: got %b want 0", bus_err_out); end
  endtask

  task automatic test_ack_on_limit();
    @(negedge clock);
    clear_inputs();
    valid_in = 1; mem_read_in = 1; mem_to_reg_in = 1; reg_write_in = 1;
    alu_result_in = 32'h40; reg_rd_in = 5'd9; dmem_rdata_in = 32'h1234;
    for (int i = 0; i < 14; i++) begin
      @(posedge clock);
      @(negedge clock);
    end
    #1;
    checks++; if (stall_out !== 1'b1) begin errors++; $display("FAIL lim_still_wait: got %b want 1", stall_out); end
    dmem_ack_in = 1;
    #1;
    checks++; if (stall_out !== 1'b0) begin errors++; $display("FAIL lim_ack_stall: got %b want 0", stall_out); end
    @(posedge clock); #1;
    checks++; if (bus_err_out !== 1'b0) begin errors++; $display("FAIL lim_bus_err: got %b want 0", bus_err_out); end
    checks++; if (valid_out !== 1'b1 || reg_write_out !== 1'b1) begin
      errors++; $display("FAIL lim_wb_ctrl: got valid=%b we=%b want 1 1", valid_out, reg_write_out);
    end
    checks++; if (alu_data_mem_wb !== 32'h1234) begin errors++; $display("FAIL lim_wb_val: got %h want 1234", alu_data_mem_wb); end
    @(negedge clock);
    clear_inputs();
    @(posedge clock); #1;
    checks++; if (bus_err_out !== 1'b0) begin errors++; $display("FAIL lim_late_err: got %b want 0", bus_err_out); end
  endtask

  task automatic test_misalign();
    @(negedge clock);
    clear_inputs();
    valid_in = 1; mem_read_in = 1; reg_write_in = 1; alu_result_in = 32'h6; reg_rd_in = 5'd4;
`ifdef MEM_MISALIGN_TRAP_EN
    #1;
    checks++; if (dmem_req_out !== 1'b0) begin errors++; $display("FAIL mis_req: got %b want 0", dmem_req_out); end
    checks++; if (stall_out !== 1'b0) begin errors++; $display("FAIL mis_stall: got %b want 0", stall_out); end
    @(posedge clock); #1;
    checks++; if (bus_err_out !== 1'b1) begin errors++; $display("FAIL mis_bus_err: got %b want 1", bus_err_out); end
    checks++; if (valid_out !== 1'b1 || reg_write_out !== 1'b0) begin
      errors++; $display("FAIL mis_wb_ctrl: got valid=%b we=%b want 1 0", valid_out, reg_write_out);
    end
`else
    dmem_ack_in = 1; dmem_rdata_in = 32'hBEEF;
    #1;
    checks++; if (dmem_req_out !== 1'b1) begin errors++; $display("FAIL mis_req: got %b want 1", dmem_req_out); end
    checks++; if (dmem_addr_out !== 10'd1) begin errors++; $display("FAIL mis_addr: got %0d want 1", dmem_addr_out); end
    @(posedge clock); #1;
    checks++; if (bus_err_out !== 1'b0) begin errors++; $display("FAIL mis_bus_err: got %b want 0", bus_err_out); end
    checks++; if (valid_out !== 1'b1 || reg_write_out !== 1'b1 || read_data_out !== 32'hBEEF) begin
      errors++; $display("FAIL mis_wb: got valid=%b we=%b rdata=%h want 1 1 beef", valid_out, reg_write_out, read_data_out);
    end
`endif
    @(negedge clock);
    clear_inputs();
    @(posedge clock); #1;
    checks++; if (bus_err_out !== 1'b0) begin errors++; $display("FAIL mis_pulse_end: got %b want 0", bus_err_out); end
  endtask

  task automatic test_reset_mid_wait();
    @(negedge clock);
    clear_inputs();
    valid_in = 1; mem_write_in = 1; alu_result_in = 32'h80; mux2_result_in = 32'h77;
    @(posedge clock);
    @(posedge clock);
    #2;
    checks++; if (dmem_req_out !== 1'b1) begin errors++; $display("FAIL rmw_pre_req: got %b want 1", dmem_req_out); end
    reset = 0;
    #1;
    checks++; if (dmem_req_out !== 1'b0) begin errors++; $display("FAIL rmw_req: got %b want 0", dmem_req_out); end
    checks++; if (stall_out !== 1'b0) begin errors++; $display("FAIL rmw_stall: got %b want 0", stall_out); end
    checks++; if (alu_result_out !== 32'h0 || valid_out !== 1'b0) begin
      errors++; $display("FAIL rmw_wb_clear: got alu=%h valid=%b want 0 0", alu_result_out, valid_out);
    end
    clear_inputs();
    @(negedge clock);
    reset = 1;
    @(posedge clock); #1;
    checks++; if (bus_err_out !== 1'b0) begin errors++; $display("FAIL rmw_bus_err: got %b want 0", bus_err_out); end
    checks++; if (dmem_req_out !== 1'b0) begin errors++; $display("FAIL rmw_post_req: got %b want 0", dmem_req_out); end
  endtask

  initial begin
    clear_inputs();
    test_reset();
    test_alu_op();
    test_back_to_back();
    test_zero_wait_load();
    test_store_wait();
    test_beq();
    test_timeout();
    test_ack_on_limit();
    test_misalign();
    test_reset_mid_wait();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
